rtm_d2c: RTL and testbench
==========================

Name: rtm_d2c

Overview:
- Loads a contiguous block from DRAM into the RTM (on-chip tensor memory); the load-direction counterpart of the RTM-to-DRAM write-back path.
- Issues one DMA read descriptor and accepts the DMA read AXI-Stream.
- Packs N = S*R*8/DW narrow DRAM beats into one full-width RTM row.
- Writes the packed rows to consecutive RTM addresses starting at c_addr.

Parameters:
- DW, 512, DRAM AXI-Stream data width (bits).
- S, 4, RTM slices.
- R, 32, bytes per slice row; one RTM row is S*R bytes. S*R*8 must be a multiple of DW, and N = S*R*8/DW is a power of two ≥ 1.
- RTM_DEPTH, 4096, rows per slice; AW = clog2(RTM_DEPTH).
- ADDR_W, 32, DMA descriptor address width.
- LEN_W, 20, DMA descriptor length width.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, reset; synchronous, active-low.
- start_pulse, in, 1, 1-cycle start command.
- d_addr, in, 32, DRAM byte address.
- c_addr, in, 32, RTM start row; low AW bits used.
- n_bytes, in, 32, transfer size; multiple of S*R and > 0.
- done_pulse, out, 1, 1-cycle completion strobe.
- err, out, 1, sticky framing error; cleared by start_pulse.
- busy, out, 1, transfer in progress.
- dma_rd_desc_addr, out, ADDR_W, descriptor address.
- dma_rd_desc_len, out, LEN_W, descriptor byte length.
- dma_rd_desc_valid, out, 1, descriptor strobe.
- dma_rd_desc_status_valid, in, 1, DMA completion status.
- dma_rd_read_data_tdata, in, DW, stream data.
- dma_rd_read_data_tvalid, in, 1, stream valid.
- dma_rd_read_data_tready, out, 1, stream ready.
- dma_rd_read_data_tlast, in, 1, stream last.
- rtm_wr_vld, out, 1, row write strobe.
- rtm_wr_last, out, 1, final row of the transfer.
- rtm_wr_en, out, S, per-slice write enable.
- rtm_wr_addr, out, S*AW, per-slice row address; all slices carry the same value.
- rtm_din, out, S*R*8, row data.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - All outputs go to 0; FSM goes to IDLE; counters and lane index clear.
  - Reset mid-transfer abandons the transfer with no done_pulse. The DMA engine must be reset alongside.
- FSM states: IDLE, DESC, STREAM, WAIT_STS.
  - IDLE: start_pulse latches d_addr, c_addr[AW-1:0] into next_addr, n_bytes, and rows_m1 = n_bytes/(S*R) - 1. It also clears err, sets busy, and moves to DESC.
  - start_pulse outside IDLE is ignored.
  - DESC: for exactly one cycle, dma_rd_desc_valid=1 with addr=d_addr and len=n_bytes[LEN_W-1:0]. Then move to STREAM. Descriptor valid therefore appears 1 cycle after start_pulse.
  - STREAM: tready=1. A beat is accepted when tvalid&tready.
    - Accepted beat data goes to lane lane_idx, i.e. bits [lane_idx*DW +: DW] of the row buffer, and lane_idx increments mod N.
    - Beat 0 of a row is the least-significant lane, matching write-back lane order.
    - On the beat that fills lane N-1, the next cycle (latency 1) asserts rtm_wr_vld=1, rtm_wr_en=all ones, rtm_wr_addr={S{next_addr}}, and rtm_din=the full row. next_addr and the row count then increment.
    - next_addr wraps modulo RTM_DEPTH.
    - On the row where row count == rows_m1, rtm_wr_last=1 and the FSM moves to WAIT_STS; tready=0 from the following cycle.
    - tready is 0 in IDLE, DESC and WAIT_STS.
  - WAIT_STS: done_pulse is asserted 1 cycle after both conditions hold: the last row has been written and status has been seen.
    - status_valid is captured into a sticky flag in any non-IDLE state, so status arriving before, with, or after the last row write is handled.
    - After done_pulse: busy=0 and return to IDLE.
- Framing errors (all set err=1 but do not stall):
  - tlast on a beat that is not the final beat of the final row: the partial row is flushed with unfilled lanes zero and written as the last row; then WAIT_STS.
  - Missing tlast on the final beat: err=1, completes normally.
- Throughput: 1 beat/cycle sustained; 1 RTM row write every N accepted beats. The RTM write port never back-pressures.
- rtm_din holds its value between writes; only the strobes return to 0.

Test Plan:
- Defaults (N=2): start d_addr=0x1000, c_addr=5, n_bytes=384 (3 rows). Stream 6 beats with continuous tvalid and tlast on beat 6; status 4 cycles later.
  - Expected: desc 1 cycle after start with len=384; row writes at addr 5,6,7, each 1 cycle after its 2nd beat; rtm_wr_last on addr 7; done_pulse 1 cycle after status; err=0.
- Same transfer with tvalid toggling 1/0 every cycle.
  - Expected: identical RTM contents and addresses; rows written 1 cycle after each completing beat.
- Status asserted in the same cycle as the last beat, and separately 10 cycles before it.
  - Expected: exactly one done_pulse, 1 cycle after the last row write.
- Wrap: c_addr=4095, n_bytes=256.
  - Expected: rows written at 4095 then 0.
- Early tlast on beat 3 of a 3-row transfer.
  - Expected: row 2 written with lane 1 zero, rtm_wr_last=1, err=1, done_pulse after status.
- Reset mid-STREAM after 3 beats, then a new start of 1 row.
  - Expected: outputs 0 during reset, no done_pulse for the aborted transfer; the new transfer writes a single row at its c_addr with correct lane order.

Source files
------------

// File: rtl/rtm_d2c.sv
// DRAM-to-RTM load: one read descriptor, packs N stream beats per row; row write 1 cycle after its completing beat.
// Accepts 1 beat/cycle in STREAM (tready low elsewhere); RTM write port never stalls.
module rtm_d2c #(
    parameter int DW        = 512,
    parameter int S         = 4,
    parameter int R         = 32,
    parameter int RTM_DEPTH = 4096,
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 20
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_pulse,
    input  logic [31:0]                 d_addr,
    input  logic [31:0]                 c_addr,
    input  logic [31:0]                 n_bytes,
    output logic                        done_pulse,
    output logic                        err,
    output logic                        busy,
    output logic [ADDR_W-1:0]           dma_rd_desc_addr,
    output logic [LEN_W-1:0]            dma_rd_desc_len,
    output logic                        dma_rd_desc_valid,
    input  logic                        dma_rd_desc_status_valid,
    input  logic [DW-1:0]               dma_rd_read_data_tdata,
    input  logic                        dma_rd_read_data_tvalid,
    output logic                        dma_rd_read_data_tready,
    input  logic                        dma_rd_read_data_tlast,
    output logic                        rtm_wr_vld,
    output logic                        rtm_wr_last,
    output logic [S-1:0]                rtm_wr_en,
    output logic [S*$clog2(RTM_DEPTH)-1:0] rtm_wr_addr,
    output logic [S*R*8-1:0]            rtm_din
);

    localparam int ROW_W     = S * R * 8;
    localparam int ROW_BYTES = S * R;
    localparam int N         = ROW_W / DW;
    localparam int AW        = $clog2(RTM_DEPTH);
    localparam int LW        = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, DESC, STREAM, WAIT_STS} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   desc_addr_q;
    logic [LEN_W-1:0]    desc_len_q;
    logic                desc_vld_q;
    logic [AW-1:0]       next_addr_q;
    logic [31:0]         rows_m1_q;
    logic [31:0]         row_cnt_q;
    logic [LW-1:0]       lane_q;
    logic [ROW_W-1:0]    row_buf_q;
    logic                sts_seen_q;
    logic                wr_done_q;
    logic                err_q;
    logic                busy_q;
    logic                done_q;
    logic                wr_vld_q;
    logic                wr_last_q;
    logic [S-1:0]        wr_en_q;
    logic [S*AW-1:0]     wr_addr_q;
    logic [ROW_W-1:0]    din_q;

    logic                beat;
    logic                row_full;
    logic                final_row;
    logic                final_beat;
    logic                row_end;
    logic [AW-1:0]       addr_inc;
    logic [ROW_W-1:0]    row_mrg;
    logic                last_wr_seen;
    logic                sts_now;
    logic                unused_c_addr;

    assign unused_c_addr = ^c_addr[31:AW];

    assign dma_rd_read_data_tready = (state_q == STREAM);
    assign beat       = dma_rd_read_data_tvalid && (state_q == STREAM);
    assign row_full   = (lane_q == LW'(N - 1));
    assign final_row  = (row_cnt_q == rows_m1_q);
    assign final_beat = final_row && row_full;
    // An early tlast flushes the partial row and ends the transfer.
    assign row_end    = row_full || dma_rd_read_data_tlast;
    assign addr_inc   = (next_addr_q == AW'(RTM_DEPTH - 1)) ? '0 : next_addr_q + 1'b1;

    assign last_wr_seen = wr_done_q || (wr_vld_q && wr_last_q);
    assign sts_now      = sts_seen_q || dma_rd_desc_status_valid;

    // Lane 0 starts a fresh row so lanes left unfilled by an early tlast read as zero.
    always_comb begin
        row_mrg = (lane_q == '0) ? '0 : row_buf_q;
        row_mrg[lane_q*DW +: DW] = dma_rd_read_data_tdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            desc_addr_q <= '0;
            desc_len_q  <= '0;
            desc_vld_q  <= 1'b0;
            next_addr_q <= '0;
            rows_m1_q   <= '0;
            row_cnt_q   <= '0;
            lane_q      <= '0;
            row_buf_q   <= '0;
            sts_seen_q  <= 1'b0;
            wr_done_q   <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_vld_q    <= 1'b0;
            wr_last_q   <= 1'b0;
            wr_en_q     <= '0;
            wr_addr_q   <= '0;
            din_q       <= '0;
        end else begin
            done_q     <= 1'b0;
            desc_vld_q <= 1'b0;
            wr_vld_q   <= 1'b0;
            wr_last_q  <= 1'b0;
            wr_en_q    <= '0;

            if (state_q != IDLE && dma_rd_desc_status_valid) begin
                sts_seen_q <= 1'b1;
            end
            if (wr_vld_q && wr_last_q) begin
                wr_done_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start_pulse) begin
                        desc_addr_q <= d_addr[ADDR_W-1:0];
                        desc_len_q  <= n_bytes[LEN_W-1:0];
                        desc_vld_q  <= 1'b1;
                        next_addr_q <= c_addr[AW-1:0];
                        rows_m1_q   <= n_bytes / ROW_BYTES - 32'd1;
                        row_cnt_q   <= '0;
                        lane_q      <= '0;
                        err_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        sts_seen_q  <= 1'b0;
                        wr_done_q   <= 1'b0;
                        state_q     <= DESC;
                    end
                end
                DESC: begin
                    state_q <= STREAM;
                end
                STREAM: begin
                    if (beat) begin
                        row_buf_q <= row_mrg;
                        if (dma_rd_read_data_tlast != final_beat) begin
                            err_q <= 1'b1;
                        end
                        if (row_end) begin
                            wr_vld_q    <= 1'b1;
                            wr_en_q     <= '1;
                            wr_addr_q   <= {S{next_addr_q}};
                            din_q       <= row_mrg;
                            wr_last_q   <= final_row || dma_rd_read_data_tlast;
                            next_addr_q <= addr_inc;
                            row_cnt_q   <= row_cnt_q + 32'd1;
                            lane_q      <= '0;
                            if (final_row || dma_rd_read_data_tlast) begin
                                state_q <= WAIT_STS;
                            end
                        end else begin
                            lane_q <= lane_q + 1'b1;
                        end
                    end
                end
                WAIT_STS: begin
                    if (last_wr_seen && sts_now) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done_pulse        = done_q;
    assign err               = err_q;
    assign busy              = busy_q;
    assign dma_rd_desc_addr  = desc_addr_q;
    assign dma_rd_desc_len   = desc_len_q;
    assign dma_rd_desc_valid = desc_vld_q;
    assign rtm_wr_vld        = wr_vld_q;
    assign rtm_wr_last       = wr_last_q;
    assign rtm_wr_en         = wr_en_q;
    assign rtm_wr_addr       = wr_addr_q;
    assign rtm_din           = din_q;

endmodule

// File: tb/tb_rtm_d2c.sv
// Directed bench for rtm_d2c at default parameters (N=2 beats per row).
module tb_rtm_d2c;

    localparam int DW = 512;
    localparam int S  = 4;
    localparam int R  = 32;
    localparam int RW = S * R * 8;
    localparam int AW = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_pulse;
    logic [31:0]       d_addr, c_addr, n_bytes;
    logic              done_pulse, err, busy;
    logic [31:0]       dma_rd_desc_addr;
    logic [19:0]       dma_rd_desc_len;
    logic              dma_rd_desc_valid;
    logic              dma_rd_desc_status_valid;
    logic [DW-1:0]     tdata;
    logic              tvalid, tready, tlast;
    logic              rtm_wr_vld, rtm_wr_last;
    logic [S-1:0]      rtm_wr_en;
    logic [S*AW-1:0]   rtm_wr_addr;
    logic [RW-1:0]     rtm_din;

    always #5 clk = ~clk;

    rtm_d2c dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .start_pulse              (start_pulse),
        .d_addr                   (d_addr),
        .c_addr                   (c_addr),
        .n_bytes                  (n_bytes),
        .done_pulse               (done_pulse),
        .err                      (err),
        .busy                     (busy),
        .dma_rd_desc_addr         (dma_rd_desc_addr),
        .dma_rd_desc_len          (dma_rd_desc_len),
        .dma_rd_desc_valid        (dma_rd_desc_valid),
        .dma_rd_desc_status_valid (dma_rd_desc_status_valid),
        .dma_rd_read_data_tdata   (tdata),
        .dma_rd_read_data_tvalid  (tvalid),
        .dma_rd_read_data_tready  (tready),
        .dma_rd_read_data_tlast   (tlast),
        .rtm_wr_vld               (rtm_wr_vld),
        .rtm_wr_last              (rtm_wr_last),
        .rtm_wr_en                (rtm_wr_en),
        .rtm_wr_addr              (rtm_wr_addr),
        .rtm_din                  (rtm_din)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    int              desc_cyc_log[$];
    logic [31:0]     desc_addr_log[$];
    logic [19:0]     desc_len_log[$];
    int              wr_cyc_log[$];
    logic [S*AW-1:0] wr_addr_log[$];
    logic [S-1:0]    wr_en_log[$];
    logic [RW-1:0]   wr_dat_log[$];
    bit              wr_last_log[$];
    int              done_cyc_log[$];
    int              acc_q[$];
    int              start_cyc;

    always @(negedge clk) begin
        if (dma_rd_desc_valid) begin
            desc_cyc_log.push_back(cyc);
            desc_addr_log.push_back(dma_rd_desc_addr);
            desc_len_log.push_back(dma_rd_desc_len);
        end
        if (rtm_wr_vld) begin
            wr_cyc_log.push_back(cyc);
            wr_addr_log.push_back(rtm_wr_addr);
            wr_en_log.push_back(rtm_wr_en);
            wr_dat_log.push_back(rtm_din);
            wr_last_log.push_back(rtm_wr_last);
        end
        if (done_pulse) done_cyc_log.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h (hi %0h) expected %0h (hi %0h)", tag,
                     got[127:0], got[RW-1:RW-128], exp[127:0], exp[RW-1:RW-128]);
        end
    endtask

    function automatic logic [DW-1:0] beat_dat(input int seed, input int i);
        logic [31:0] w;
        w = seed + i;
        return {16{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [31:0] d, input logic [31:0] c, input logic [31:0] n);
        desc_cyc_log.delete(); desc_addr_log.delete(); desc_len_log.delete();
        wr_cyc_log.delete(); wr_addr_log.delete(); wr_en_log.delete();
        wr_dat_log.delete(); wr_last_log.delete(); done_cyc_log.delete();
        acc_q.delete();
        start_pulse = 1'b1;
        d_addr      = d;
        c_addr      = c;
        n_bytes     = n;
        start_cyc   = cyc;
        tick();
        start_pulse = 1'b0;
    endtask

    // Presents nbeats beats; tlast on beat index tlast_at (-1 = never).
    task automatic stream(input int nbeats, input int seed, input bit toggle,
                          input int tlast_at, input bit sts_with_last);
        int  i, w, guard;
        bit  ph, pres, acc;
        w = 0;
        while (!tready && w < 20) begin
            tick();
            w++;
        end
        if (!tready) chk("tready_timeout", RW'(0), RW'(1));
        i = 0; ph = 1'b0; guard = 0;
        while (i < nbeats && guard < 200) begin
            pres   = toggle ? !ph : 1'b1;
            tvalid = pres;
            tdata  = beat_dat(seed, i);
            tlast  = (i == tlast_at);
            acc    = pres && tready;
            dma_rd_desc_status_valid = sts_with_last && acc && (i == nbeats - 1);
            if (acc) acc_q.push_back(cyc);
            tick();
            if (acc) i++;
            ph = !ph;
            guard++;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        dma_rd_desc_status_valid = 1'b0;
        if (i < nbeats) chk("stream_timeout", RW'(i), RW'(nbeats));
    endtask

    task automatic sts_after_last(output int sc);
        tick(); tick(); tick();
        dma_rd_desc_status_valid = 1'b1;
        sc = cyc;
        tick();
        dma_rd_desc_status_valid = 1'b0;
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while (done_cyc_log.size() == 0 && w < 40) begin
            tick();
            w++;
        end
        tick(); tick();
    endtask

    task automatic verify(input string tag, input int nrows, input logic [AW-1:0] c0,
                          input logic [31:0] d, input logic [31:0] nb, input int seed,
                          input bit early, input int exp_done, input bit exp_err);
        logic [AW-1:0] a;
        logic [DW-1:0] hi;
        int            bi;
        chk({tag, "_desc_n"}, RW'(desc_cyc_log.size()), RW'(1));
        if (desc_cyc_log.size() > 0) begin
            chk({tag, "_desc_cyc"}, RW'(desc_cyc_log[0]), RW'(start_cyc + 1));
            chk({tag, "_desc_addr"}, RW'(desc_addr_log[0]), RW'(d));
            chk({tag, "_desc_len"}, RW'(desc_len_log[0]), RW'(nb[19:0]));
        end
        chk({tag, "_wr_n"}, RW'(wr_cyc_log.size()), RW'(nrows));
        for (int r = 0; r < nrows && r < wr_cyc_log.size(); r++) begin
            a  = c0 + AW'(r);
            hi = (early && r == nrows - 1) ? '0 : beat_dat(seed, 2 * r + 1);
            chk($sformatf("%s_addr%0d", tag, r), RW'(wr_addr_log[r]), RW'({S{a}}));
            chk($sformatf("%s_en%0d", tag, r), RW'(wr_en_log[r]), RW'(4'hf));
            chk($sformatf("%s_dat%0d", tag, r), wr_dat_log[r], {hi, beat_dat(seed, 2 * r)});
            chk($sformatf("%s_last%0d", tag, r), RW'(wr_last_log[r]), RW'(r == nrows - 1));
            if (acc_q.size() > 0) begin
                bi = (2 * r + 1 < acc_q.size()) ? 2 * r + 1 : acc_q.size() - 1;
                chk($sformatf("%s_wcyc%0d", tag, r), RW'(wr_cyc_log[r]), RW'(acc_q[bi] + 1));
            end
        end
        chk({tag, "_done_n"}, RW'(done_cyc_log.size()), RW'(1));
        if (done_cyc_log.size() > 0)
            chk({tag, "_done_cyc"}, RW'(done_cyc_log[0]), RW'(exp_done));
        chk({tag, "_err"}, RW'(err), RW'(exp_err));
        chk({tag, "_busy_end"}, RW'(busy), RW'(0));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk(tag, RW'({busy, done_pulse, err, dma_rd_desc_valid, tready, rtm_wr_vld,
                      rtm_wr_last, rtm_wr_en, rtm_wr_addr, dma_rd_desc_addr, dma_rd_desc_len}),
            RW'(0));
        chk({tag, "_din"}, rtm_din, RW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        int sc;
        int last;
        rst_n = 1'b0; start_pulse = 1'b0; d_addr = '0; c_addr = '0; n_bytes = '0;
        dma_rd_desc_status_valid = 1'b0; tdata = '0; tvalid = 1'b0; tlast = 1'b0;
        repeat (3) tick();
        chk_reset_outs("reset");
        rst_n = 1'b1;
        tick();

        // Basic 3-row transfer, status 4 cycles after last beat.
        start_xfer(32'h1000, 32'd5, 32'd384);
        chk("t1_busy", RW'(busy), RW'(1));
        stream(6, 32'h100, 1'b0, 5, 1'b0);
        sts_after_last(sc);
        wait_done();
        verify("t1", 3, 12'd5, 32'h1000, 32'd384, 32'h100, 1'b0, sc + 1, 1'b0);

        // tvalid toggling.
        start_xfer(32'h1000, 32'd5, 32'd384);
        stream(6, 32'h200, 1'b1, 5, 1'b0);
        sts_after_last(sc);
        wait_done();
        verify("t2", 3, 12'd5, 32'h1000, 32'd384, 32'h200, 1'b0, sc + 1, 1'b0);

        // Status together with the last beat.
        start_xfer(32'h1000, 32'd5, 32'd384);
        stream(6, 32'h300, 1'b0, 5, 1'b1);
        last = (acc_q.size() > 0) ? acc_q[acc_q.size() - 1] : 0;
        wait_done();
        verify("t3", 3, 12'd5, 32'h1000, 32'd384, 32'h300, 1'b0, last + 2, 1'b0);

        // Status well before the stream.
        start_xfer(32'h1000, 32'd5, 32'd384);
        dma_rd_desc_status_valid = 1'b1;
        tick();
        dma_rd_desc_status_valid = 1'b0;
        repeat (10) tick();
        stream(6, 32'h400, 1'b0, 5, 1'b0);
        last = (acc_q.size() > 0) ? acc_q[acc_q.size() - 1] : 0;
        wait_done();
        verify("t4", 3, 12'd5, 32'h1000, 32'd384, 32'h400, 1'b0, last + 2, 1'b0);

        // Address wrap at the top of the RTM.
        start_xfer(32'h8000, 32'd4095, 32'd256);
        stream(4, 32'h500, 1'b0, 3, 1'b0);
        sts_after_last(sc);
        wait_done();
        verify("t5", 2, 12'd4095, 32'h8000, 32'd256, 32'h500, 1'b0, sc + 1, 1'b0);

        // Early tlast on beat 3 of a 3-row transfer.
        start_xfer(32'h2000, 32'd10, 32'd384);
        stream(3, 32'h600, 1'b0, 2, 1'b0);
        sts_after_last(sc);
        wait_done();
        verify("t6", 2, 12'd10, 32'h2000, 32'd384, 32'h600, 1'b1, sc + 1, 1'b1);

        // Missing tlast; err from t6 must clear at start.
        start_xfer(32'h3000, 32'd9, 32'd128);
        chk("t7_err_clr", RW'(err), RW'(0));
        stream(2, 32'h700, 1'b0, -1, 1'b0);
        sts_after_last(sc);
        wait_done();
        verify("t7", 1, 12'd9, 32'h3000, 32'd128, 32'h700, 1'b0, sc + 1, 1'b1);

        // Reset mid-stream, then a fresh 1-row transfer.
        start_xfer(32'h4000, 32'd20, 32'd384);
        stream(3, 32'h800, 1'b0, -1, 1'b0);
        rst_n = 1'b0;
        tick();
        chk_reset_outs("t8_rst_a");
        tick();
        chk_reset_outs("t8_rst_b");
        rst_n = 1'b1;
        repeat (5) tick();
        chk("t8_no_done", RW'(done_cyc_log.size()), RW'(0));
        start_xfer(32'h5000, 32'd77, 32'd128);
        stream(2, 32'h900, 1'b0, 1, 1'b0);
        sts_after_last(sc);
        wait_done();
        verify("t8", 1, 12'd77, 32'h5000, 32'd128, 32'h900, 1'b0, sc + 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
